// File: rtl/mips_cpu_hilo_ctrl_if.sv
// Issue, read-back and HI/LO unit signals between decode/execute, the
// HI/LO sequencer and the multiply-divide unit.
interface mips_cpu_hilo_ctrl_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 6;

   logic              issue_valid;
   logic [OP_W-1:0]   issue_opcode;
   logic [DATA_W-1:0] issue_a;
   logic [DATA_W-1:0] issue_b;
   logic              issue_ready;

   logic              rd_req;
   logic              rd_hi_sel;
   logic              rd_stall;
   logic [DATA_W-1:0] rd_data;

   logic [OP_W-1:0]   unit_opcode;
   logic [DATA_W-1:0] unit_a;
   logic [DATA_W-1:0] unit_b;
   logic              unit_valid_in;
   logic              unit_valid_out;
   logic [DATA_W-1:0] unit_hi;
   logic [DATA_W-1:0] unit_lo;

   logic              busy;
   logic              div_zero;
   logic              timeout_err;
   logic              illegal_op;

   // Pipeline plus HI/LO unit side
   modport master (
      output issue_valid, issue_opcode, issue_a, issue_b,
      output rd_req, rd_hi_sel,
      output unit_valid_out, unit_hi, unit_lo,
      input  issue_ready, rd_stall, rd_data,
      input  unit_opcode, unit_a, unit_b, unit_valid_in,
      input  busy, div_zero, timeout_err, illegal_op
   );

   // Sequencer side
   modport slave (
      input  issue_valid, issue_opcode, issue_a, issue_b,
      input  rd_req, rd_hi_sel,
      input  unit_valid_out, unit_hi, unit_lo,
      output issue_ready, rd_stall, rd_data,
      output unit_opcode, unit_a, unit_b, unit_valid_in,
      output busy, div_zero, timeout_err, illegal_op
   );
endinterface

// File: rtl/mips_cpu_hilo_ctrl.sv
// Sequencer for the HI/LO multiply-divide unit: holds opcode/operands for the
// cycles each operation needs, then parks the unit on the idle opcode.
module mips_cpu_hilo_ctrl #(
   parameter int unsigned DIV_TIMEOUT = 40
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   mips_cpu_hilo_ctrl_if.slave  hilo_if
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned CNT_W  = $clog2(DIV_TIMEOUT + 1);

   localparam logic [OP_W-1:0] OP_IDLE  = 6'b000000;
   localparam logic [OP_W-1:0] OP_MULT  = 6'b011000;
   localparam logic [OP_W-1:0] OP_MULTU = 6'b011001;
   localparam logic [OP_W-1:0] OP_DIV   = 6'b011010;
   localparam logic [OP_W-1:0] OP_DIVU  = 6'b011011;
   localparam logic [OP_W-1:0] OP_MTHI  = 6'b010001;
   localparam logic [OP_W-1:0] OP_MTLO  = 6'b010011;

   typedef enum logic [2:0] {
      S_IDLE, S_MUL1, S_MUL2, S_MOVE, S_DIV_START, S_DIV_RUN, S_DIV_WB
   } state_e;

   state_e            state_q, state_d;
   logic [OP_W-1:0]   opcode_q, opcode_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              valid_in_q, valid_in_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              div_zero_q, div_zero_d;
   logic              tout_q, tout_d;
   logic              illegal_q, illegal_d;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= S_IDLE;
         opcode_q   <= OP_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         valid_in_q <= 1'b0;
         cnt_q      <= '0;
         div_zero_q <= 1'b0;
         tout_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         opcode_q   <= opcode_d;
         a_q        <= a_d;
         b_q        <= b_d;
         valid_in_q <= valid_in_d;
         cnt_q      <= cnt_d;
         div_zero_q <= div_zero_d;
         tout_q     <= tout_d;
         illegal_q  <= illegal_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      a_d        = a_q;
      b_d        = b_q;
      valid_in_d = 1'b0;
      cnt_d      = cnt_q;
      div_zero_d = 1'b0;
      tout_d     = tout_q;
      illegal_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (hilo_if.issue_valid) begin
               case (hilo_if.issue_opcode)
                  OP_MULT, OP_MULTU: begin
                     opcode_d = hilo_if.issue_opcode;
                     a_d      = hilo_if.issue_a;
                     b_d      = hilo_if.issue_b;
                     state_d  = S_MUL1;
                  end
                  OP_DIV, OP_DIVU: begin
                     // A zero divisor is dropped before the unit ever sees it
                     if (hilo_if.issue_b == '0) begin
                        div_zero_d = 1'b1;
                     end else begin
                        opcode_d   = hilo_if.issue_opcode;
                        a_d        = hilo_if.issue_a;
                        b_d        = hilo_if.issue_b;
                        valid_in_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_DIV_START;
                     end
                  end
                  OP_MTHI, OP_MTLO: begin
                     opcode_d = hilo_if.issue_opcode;
                     a_d      = hilo_if.issue_a;
                     b_d      = hilo_if.issue_b;
                     state_d  = S_MOVE;
                  end
                  default: illegal_d = 1'b1;
               endcase
            end
         end
         S_MUL1:      state_d = S_MUL2;
         S_MUL2, S_MOVE, S_DIV_WB: begin
            opcode_d = OP_IDLE;
            state_d  = S_IDLE;
         end
         S_DIV_START: begin
            // unit_valid_out is not looked at here: it may be left over
            cnt_d   = '0;
            state_d = S_DIV_RUN;
         end
         S_DIV_RUN: begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
            if (hilo_if.unit_valid_out) begin
               state_d = S_DIV_WB;
            end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
               opcode_d = OP_IDLE;
               tout_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            opcode_d = OP_IDLE;
            state_d  = S_IDLE;
         end
      endcase
   end

   assign hilo_if.issue_ready   = (state_q == S_IDLE);
   assign hilo_if.busy          = (state_q != S_IDLE);
   assign hilo_if.rd_stall      = hilo_if.rd_req && (state_q != S_IDLE);
   assign hilo_if.rd_data       = hilo_if.rd_hi_sel ? hilo_if.unit_hi : hilo_if.unit_lo;
   assign hilo_if.unit_opcode   = opcode_q;
   assign hilo_if.unit_a        = a_q;
   assign hilo_if.unit_b        = b_q;
   assign hilo_if.unit_valid_in = valid_in_q;
   assign hilo_if.div_zero      = div_zero_q;
   assign hilo_if.timeout_err   = tout_q;
   assign hilo_if.illegal_op    = illegal_q;
endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// Directed bench for mips_cpu_hilo_ctrl with a behavioural HI/LO unit that
// needs 34 cycles per divide.
module tb_mips_cpu_hilo_ctrl;
   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MTLO  = 6'b010011;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          exp_cyc;
      int          exp_vin;
      logic        exp_dz;
      logic        exp_il;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   mips_cpu_hilo_ctrl_if hif ();

   mips_cpu_hilo_ctrl #(.DIV_TIMEOUT(40)) dut (
      .clk_i    (clk),
      .reset_ni (rst_n),
      .hilo_if  (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural unit: mult result appears one cycle late, divide takes 34 cycles
   logic [31:0] m_hi, m_lo, m_q, m_r;
   logic [63:0] m_prod;
   logic [5:0]  m_dcnt;
   logic        m_run, m_wb;
   logic        kill_vo, force_vo;

   assign hif.unit_hi        = m_hi;
   assign hif.unit_lo        = m_lo;
   assign hif.unit_valid_out = (m_run && (m_dcnt == 6'd0) && !kill_vo) || force_vo;

   always @(posedge clk) begin
      case (hif.unit_opcode)
         OP_MULT: begin
            m_prod <= {{32{hif.unit_a[31]}}, hif.unit_a} * {{32{hif.unit_b[31]}}, hif.unit_b};
            m_hi   <= m_prod[63:32];
            m_lo   <= m_prod[31:0];
         end
         OP_MULTU: begin
            m_prod <= {32'd0, hif.unit_a} * {32'd0, hif.unit_b};
            m_hi   <= m_prod[63:32];
            m_lo   <= m_prod[31:0];
         end
         OP_MTHI: m_hi <= hif.unit_a;
         OP_MTLO: m_lo <= hif.unit_a;
         OP_DIV, OP_DIVU: begin
            if (m_wb) begin
               m_hi <= m_r;
               m_lo <= m_q;
               m_wb <= 1'b0;
            end
         end
         default: ;
      endcase
      if (hif.unit_valid_in) begin
         m_run  <= 1'b1;
         m_dcnt <= 6'd33;
         m_wb   <= 1'b0;
         if (hif.unit_opcode == OP_DIV) begin
            m_q <= $signed(hif.unit_a) / $signed(hif.unit_b);
            m_r <= $signed(hif.unit_a) % $signed(hif.unit_b);
         end else begin
            m_q <= hif.unit_a / hif.unit_b;
            m_r <= hif.unit_a % hif.unit_b;
         end
      end else if (m_run && !kill_vo) begin
         if (m_dcnt == 6'd0) begin
            m_run <= 1'b0;
            m_wb  <= 1'b1;
         end else begin
            m_dcnt <= m_dcnt - 6'd1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one operation with rd_req held, measure the busy window, then read HI/LO
   task automatic run_vec(input string tag, input vec_t v, input bit force_stale);
      int          cyc;
      int          vin;
      int          sbad;
      logic        dz;
      logic        il;
      logic [5:0]  op_after;
      @(negedge clk);
      check({tag, "_ready_pre"}, 32'(hif.issue_ready), 32'd1);
      hif.issue_valid  = 1'b1;
      hif.issue_opcode = v.op;
      hif.issue_a      = v.a;
      hif.issue_b      = v.b;
      hif.rd_req       = 1'b1;
      @(posedge clk); #1;
      hif.issue_valid = 1'b0;
      dz       = hif.div_zero;
      il       = hif.illegal_op;
      op_after = hif.unit_opcode;
      if (force_stale) force_vo = 1'b1;
      cyc  = 0;
      vin  = 0;
      sbad = 0;
      while (hif.busy && cyc < 200) begin
         cyc++;
         if (hif.unit_valid_in) vin++;
         if (hif.rd_stall !== 1'b1) sbad++;
         @(posedge clk); #1;
         force_vo = 1'b0;
      end
      force_vo = 1'b0;
      check({tag, "_busy_cycles"}, 32'(cyc), 32'(v.exp_cyc));
      check({tag, "_valid_in_cycles"}, 32'(vin), 32'(v.exp_vin));
      check({tag, "_stall_while_busy"}, 32'(sbad), 32'd0);
      check({tag, "_div_zero"}, 32'(dz), 32'(v.exp_dz));
      check({tag, "_illegal_op"}, 32'(il), 32'(v.exp_il));
      if (v.exp_cyc == 0) check({tag, "_opcode_idle"}, 32'(op_after), 32'd0);
      check({tag, "_stall_idle"}, 32'(hif.rd_stall), 32'd0);
      check({tag, "_ready_post"}, 32'(hif.issue_ready), 32'd1);
      @(posedge clk); #1;
      check({tag, "_pulses_clear"}, 32'({hif.div_zero, hif.illegal_op}), 32'd0);
      hif.rd_hi_sel = 1'b1; #1;
      check({tag, "_hi"}, hif.rd_data, v.exp_hi);
      hif.rd_hi_sel = 1'b0; #1;
      check({tag, "_lo"}, hif.rd_data, v.exp_lo);
      hif.rd_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[10];
   vec_t v;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      kill_vo  = 1'b0;
      force_vo = 1'b0;
      rst_n    = 1'b0;
      hif.issue_valid  = 1'b0;
      hif.issue_opcode = 6'd0;
      hif.issue_a      = 32'd0;
      hif.issue_b      = 32'd0;
      hif.rd_req       = 1'b0;
      hif.rd_hi_sel    = 1'b0;

      vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        2, 0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        2, 0, 1'b0, 1'b0, 32'h00000002, 32'hFFFFFFFA};
      vecs[2] = '{OP_DIVU,  32'd100,      32'd7,       36, 1, 1'b0, 1'b0, 32'h00000002, 32'h0000000E};
      vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,       36, 1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4] = '{OP_DIVU,  32'h00000055, 32'd0,        0, 0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[5] = '{OP_DIV,   32'd5,        32'd0,        0, 0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[6] = '{6'b100000, 32'd1,       32'd2,        0, 0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[7] = '{OP_MTHI,  32'hDEADBEEF, 32'd0,        1, 0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hFFFFFFFD};
      vecs[8] = '{OP_MTLO,  32'h00C0FFEE, 32'd9,        1, 0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00C0FFEE};
      vecs[9] = '{6'b010000, 32'd7,       32'd7,        0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h00C0FFEE};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(hif.issue_ready), 32'd1);
      check("rst_busy", 32'(hif.busy), 32'd0);
      check("rst_opcode", 32'(hif.unit_opcode), 32'd0);
      check("rst_a", hif.unit_a, 32'd0);
      check("rst_b", hif.unit_b, 32'd0);
      check("rst_valid_in", 32'(hif.unit_valid_in), 32'd0);
      check("rst_flags", 32'({hif.div_zero, hif.timeout_err, hif.illegal_op}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

      // Divide whose done never arrives
      kill_vo = 1'b1;
      v = '{OP_DIVU, 32'd9, 32'd3, 41, 1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00C0FFEE};
      run_vec("timeout", v, 1'b0);
      check("timeout_err_set", 32'(hif.timeout_err), 32'd1);
      kill_vo = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("timeout_err_sticky", 32'(hif.timeout_err), 32'd1);
      v = '{OP_MTHI, 32'h00001234, 32'd0, 1, 0, 1'b0, 1'b0, 32'h00001234, 32'h00C0FFEE};
      run_vec("mthi_after_timeout", v, 1'b0);

      // Stale done during DIV_START must not shorten the divide
      v = '{OP_DIVU, 32'd50, 32'd5, 36, 1, 1'b0, 1'b0, 32'h00000000, 32'h0000000A};
      run_vec("stale_done", v, 1'b1);

      // Read in the same cycle an issue is accepted sees pre-operation LO
      @(negedge clk);
      hif.issue_valid  = 1'b1;
      hif.issue_opcode = OP_MULT;
      hif.issue_a      = 32'd7;
      hif.issue_b      = 32'd6;
      hif.rd_req       = 1'b1;
      hif.rd_hi_sel    = 1'b0;
      #1;
      check("same_cycle_no_stall", 32'(hif.rd_stall), 32'd0);
      check("same_cycle_old_lo", hif.rd_data, 32'h0000000A);
      @(posedge clk); #1;
      hif.issue_valid = 1'b0;
      check("same_cycle_then_stall", 32'(hif.rd_stall), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("same_cycle_done", 32'(hif.busy), 32'd0);
      check("same_cycle_new_lo", hif.rd_data, 32'd42);
      hif.rd_req = 1'b0;

      // Reset asserted in the middle of a divide
      @(negedge clk);
      hif.issue_valid  = 1'b1;
      hif.issue_opcode = OP_DIVU;
      hif.issue_a      = 32'd1000;
      hif.issue_b      = 32'd10;
      @(posedge clk); #1;
      hif.issue_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      check("mid_div_busy", 32'(hif.busy), 32'd1);
      check("mid_div_opcode", 32'(hif.unit_opcode), 32'(OP_DIVU));
      rst_n = 1'b0;
      #1;
      check("abort_opcode", 32'(hif.unit_opcode), 32'd0);
      check("abort_ready", 32'(hif.issue_ready), 32'd1);
      check("abort_busy", 32'(hif.busy), 32'd0);
      check("abort_valid_in", 32'(hif.unit_valid_in), 32'd0);
      check("abort_timeout_err", 32'(hif.timeout_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
